leds_deser_mc: RTL and testbench

- Multi-channel, word-framed serial-to-parallel receiver driving the board LED bank.
- Shifts NUM_CH serial lines in lock-step under din_ena and counts bits to frame words.
- Captures completed words and refreshes the LED output from a selected channel at a rate-limited interval so the display is human-readable.
- Sits between the chip serial debug outputs and the FPGA LED pins.

---
 rtl/leds_deser_mc.sv | 152 +++++++++++++++
 tb/tb_leds_deser_mc.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/leds_deser_mc.sv
// Multi-channel word-framed serial-to-parallel receiver feeding the LED bank.
// Optional build macro LEDS_LIVE_VIEW_EN shows the live shift register instead of the held word.
module leds_deser_mc #(
   parameter int WORD_WIDTH  = 18,
   parameter int NUM_CH      = 2,
   parameter int HOLD_CYCLES = 10000
) (
   input  logic                                      clk,
   input  logic                                      rstn,
   input  logic [NUM_CH-1:0]                         din,
   input  logic                                      din_ena,
   input  logic                                      frame_start,
   input  logic                                      msb_first,
   input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] sel,
   output logic [WORD_WIDTH-1:0]                     leds,
   output logic                                      word_valid,
   output logic                                      word_lost
);

   localparam int BW = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;
   localparam int TW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [BW-1:0] BCNT_LAST = BW'(WORD_WIDTH - 1);
   localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_CYCLES - 1);

   logic [BW-1:0]                       bcnt_q;
   logic                                mode_q;
   logic [NUM_CH-1:0][WORD_WIDTH-1:0]   sr_q;
   logic [NUM_CH-1:0][WORD_WIDTH-1:0]   sr_next;
   logic [NUM_CH-1:0][WORD_WIDTH-1:0]   word_q;
   logic [WORD_WIDTH-1:0]               shift_base;
   logic [TW-1:0]                       hold_q;
   logic                                pending_q;
   logic                                bit_zero;
   logic                                eff_mode;
   logic                                word_done;
   logic                                refresh;

   // A bit accepted with frame_start, or at bcnt 0, opens a new word and picks its mode.
   assign bit_zero  = frame_start || (bcnt_q == '0);
   assign eff_mode  = bit_zero ? msb_first : mode_q;
   assign word_done = din_ena && !frame_start && (bcnt_q == BCNT_LAST);
   assign refresh   = (hold_q == HOLD_LAST);

   always_comb begin
      sr_next    = '0;
      shift_base = '0;
      for (int ch = 0; ch < NUM_CH; ch++) begin
         shift_base = frame_start ? '0 : sr_q[ch];
         if (eff_mode) begin
            sr_next[ch] = {shift_base[WORD_WIDTH-2:0], din[ch]};
         end else begin
            sr_next[ch] = {din[ch], shift_base[WORD_WIDTH-1:1]};
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sr_q   <= '0;
         bcnt_q <= '0;
         mode_q <= 1'b0;
      end else if (din_ena) begin
         sr_q <= sr_next;
         if (bit_zero) begin
            mode_q <= msb_first;
         end
         if (frame_start) begin
            bcnt_q <= BW'(1);
         end else if (word_done) begin
            bcnt_q <= '0;
         end else begin
            bcnt_q <= bcnt_q + BW'(1);
         end
      end else if (frame_start) begin
         sr_q   <= '0;
         bcnt_q <= '0;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         word_q     <= '0;
         word_valid <= 1'b0;
      end else begin
         if (word_done) begin
            word_q <= sr_next;
         end
         word_valid <= word_done;
      end
   end

   // A completion on the refresh cycle re-arms pending rather than counting as a loss.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         hold_q    <= '0;
         pending_q <= 1'b0;
         word_lost <= 1'b0;
      end else begin
         hold_q <= refresh ? '0 : hold_q + TW'(1);
         if (word_done) begin
            pending_q <= 1'b1;
         end else if (refresh) begin
            pending_q <= 1'b0;
         end
         if (word_done && pending_q && !refresh) begin
            word_lost <= 1'b1;
         end
      end
   end

`ifdef LEDS_LIVE_VIEW_EN
   logic [WORD_WIDTH-1:0] sel_live;

   always_comb begin
      sel_live = sr_next[0];
      for (int i = 0; i < NUM_CH; i++) begin
         if (int'(sel) == i) begin
            sel_live = sr_next[i];
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         leds <= '0;
      end else if (din_ena) begin
         leds <= sel_live;
      end
   end
`else
   logic [WORD_WIDTH-1:0] sel_word;

   // Out-of-range selects fall through to channel 0.
   always_comb begin
      sel_word = word_q[0];
      for (int i = 0; i < NUM_CH; i++) begin
         if (int'(sel) == i) begin
            sel_word = word_q[i];
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         leds <= '0;
      end else if (refresh) begin
         leds <= sel_word;
      end
   end
`endif

endmodule

// File: tb/tb_leds_deser_mc.sv
// Testbench for leds_deser_mc: directed scenarios plus randomized traffic against a bit-list model.
module tb_leds_deser_mc;

   localparam int W = 4;
   localparam int N = 2;
   localparam int H = 8;

   logic         clk = 1'b0;
   logic         rstn = 1'b1;
   logic [N-1:0] din = '0;
   logic         din_ena = 1'b0;
   logic         frame_start = 1'b0;
   logic         msb_first = 1'b0;
   logic         sel = 1'b0;
   logic [W-1:0] leds;
   logic         word_valid;
   logic         word_lost;

   int tests = 0;
   int fails = 0;

   // Reference model: bits received so far in the current word, in arrival order.
   bit           m_bits [N][W];
   int           m_cnt;
   bit           m_mode;
   logic [W-1:0] m_word [N];
   logic [W-1:0] m_leds;
   bit           m_pend;
   bit           m_lost;
   bit           m_valid;
   bit           last_refresh;
   int           cyc;
   int           nvalid;

   leds_deser_mc #(.WORD_WIDTH(W), .NUM_CH(N), .HOLD_CYCLES(H)) dut (
      .clk(clk),
      .rstn(rstn),
      .din(din),
      .din_ena(din_ena),
      .frame_start(frame_start),
      .msb_first(msb_first),
      .sel(sel),
      .leds(leds),
      .word_valid(word_valid),
      .word_lost(word_lost)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic modelReset();
      m_cnt = 0;
      m_mode = 1'b0;
      for (int c = 0; c < N; c++) m_word[c] = '0;
      m_leds = '0;
      m_pend = 1'b0;
      m_lost = 1'b0;
      m_valid = 1'b0;
      last_refresh = 1'b0;
      cyc = 0;
   endtask

   task automatic doReset();
      din = '0;
      din_ena = 1'b0;
      frame_start = 1'b0;
      rstn = 1'b0;
      #2;
      checkOutput("rst_leds", 32'(leds), 32'd0);
      checkOutput("rst_valid", 32'(word_valid), 32'd0);
      checkOutput("rst_lost", 32'(word_lost), 32'd0);
      modelReset();
      @(posedge clk);
      #1;
      rstn = 1'b1;
   endtask

   task automatic applyStimulus(input logic [N-1:0] d, input logic e, input logic fs,
                                input logic msb, input logic s);
      bit refresh;
      bit done;
      logic [W-1:0] w;
      din = d;
      din_ena = e;
      frame_start = fs;
      msb_first = msb;
      sel = s;
      @(posedge clk);
      refresh = ((cyc % H) == H - 1);
      done = 1'b0;
      if (refresh) m_leds = m_word[s];
      if (e) begin
         if (fs || m_cnt == 0) begin
            m_cnt = 0;
            m_mode = msb;
         end
         for (int c = 0; c < N; c++) m_bits[c][m_cnt] = d[c];
         m_cnt++;
         if (m_cnt == W) begin
            done = 1'b1;
            for (int c = 0; c < N; c++) begin
               w = '0;
               for (int k = 0; k < W; k++) begin
                  if (m_mode) w[W-1-k] = m_bits[c][k];
                  else        w[k]     = m_bits[c][k];
               end
               m_word[c] = w;
            end
            m_cnt = 0;
         end
      end else if (fs) begin
         m_cnt = 0;
      end
      if (done && m_pend && !refresh) m_lost = 1'b1;
      if (done) m_pend = 1'b1;
      else if (refresh) m_pend = 1'b0;
      m_valid = done;
      last_refresh = refresh;
      cyc++;
      #1;
      if (word_valid) nvalid++;
      checkOutput("leds", 32'(leds), 32'(m_leds));
      checkOutput("word_valid", 32'(word_valid), 32'(m_valid));
      checkOutput("word_lost", 32'(word_lost), 32'(m_lost));
   endtask

   task automatic idleToRefresh(input logic s);
      int guard;
      guard = 0;
      do begin
         applyStimulus('0, 1'b0, 1'b0, 1'b1, s);
         guard++;
      end while (!last_refresh && guard <= H);
   endtask

   task automatic idleUntilPhase(input int ph);
      for (int i = 0; i < H && (cyc % H) != ph; i++) applyStimulus('0, 1'b0, 1'b0, 1'b1, 1'b0);
   endtask

   task automatic sendWord(input logic [W-1:0] b0, input logic [W-1:0] b1, input logic msb);
      // b0/b1 list channel bits in send order, first bit in position W-1
      for (int k = W - 1; k >= 0; k--) applyStimulus({b1[k], b0[k]}, 1'b1, 1'b0, msb, 1'b0);
   endtask

   initial begin
      logic [W-1:0] w2;
      logic [N-1:0] rb;

      // Scenario 1: MSB-first framing and channel select
      doReset();
      nvalid = 0;
      sendWord(4'b1011, 4'b0001, 1'b1);
      checkOutput("t1_valid_count", 32'(nvalid), 32'd1);
      idleToRefresh(1'b0);
      checkOutput("t1_leds_ch0", 32'(leds), 32'(4'b1011));
      idleToRefresh(1'b1);
      checkOutput("t1_leds_ch1", 32'(leds), 32'(4'b0001));

      // Scenario 2: LSB-first, and mode change mid-word is ignored
      sendWord(4'b1011, 4'b0000, 1'b0);
      idleToRefresh(1'b0);
      checkOutput("t2_lsb", 32'(leds), 32'(4'b1101));
      applyStimulus(2'b01, 1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus(2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus(2'b01, 1'b1, 1'b0, 1'b1, 1'b0);
      applyStimulus(2'b01, 1'b1, 1'b0, 1'b1, 1'b0);
      idleToRefresh(1'b0);
      checkOutput("t2_toggle", 32'(leds), 32'(4'b1101));

      // Scenario 3: frame_start alone discards a partial word
      nvalid = 0;
      applyStimulus(2'b01, 1'b1, 1'b0, 1'b1, 1'b0);
      applyStimulus(2'b00, 1'b1, 1'b0, 1'b1, 1'b0);
      applyStimulus(2'b00, 1'b0, 1'b1, 1'b1, 1'b0);
      sendWord(4'b1110, 4'b0000, 1'b1);
      checkOutput("t3_valid_count", 32'(nvalid), 32'd1);
      idleToRefresh(1'b0);
      checkOutput("t3_leds", 32'(leds), 32'(4'b1110));

      // Scenario 4: frame_start together with din_ena starts a new word
      applyStimulus(2'b00, 1'b1, 1'b0, 1'b1, 1'b0);
      applyStimulus(2'b01, 1'b1, 1'b1, 1'b1, 1'b0);
      applyStimulus(2'b00, 1'b1, 1'b0, 1'b1, 1'b0);
      applyStimulus(2'b00, 1'b1, 1'b0, 1'b1, 1'b0);
      applyStimulus(2'b00, 1'b1, 1'b0, 1'b1, 1'b0);
      idleToRefresh(1'b0);
      checkOutput("t4_leds", 32'(leds), 32'(4'b1000));

      // Scenario 5: two words inside one hold window
      idleUntilPhase(H - 3);
      w2 = '0;
      for (int k = 0; k < 2 * W; k++) begin
         rb = 2'($urandom_range(0, 3));
         if (k >= W) w2[2*W-1-k] = rb[0];
         applyStimulus(rb, 1'b1, 1'b0, 1'b1, 1'b0);
      end
      checkOutput("t5_lost", 32'(word_lost), 32'd1);
      idleToRefresh(1'b0);
      checkOutput("t5_leds", 32'(leds), 32'(w2));
      checkOutput("t5_lost_sticky", 32'(word_lost), 32'd1);
      doReset();

      // Scenario 6: completion coincident with refresh
      sendWord(4'b0110, 4'b0000, 1'b1);
      idleToRefresh(1'b0);
      checkOutput("t6_first", 32'(leds), 32'(4'b0110));
      idleUntilPhase(H - W);
      sendWord(4'b1001, 4'b0000, 1'b1);
      checkOutput("t6_hold_old", 32'(leds), 32'(4'b0110));
      checkOutput("t6_no_loss", 32'(word_lost), 32'd0);
      idleToRefresh(1'b0);
      checkOutput("t6_next", 32'(leds), 32'(4'b1001));

      // Randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         applyStimulus(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                       ($urandom_range(0, 19) == 0), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)));
         if (i == 200) doReset();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
